multi_blinker: RTL

- N-channel successor to the single-output square-wave blinker.
- Each channel has a run-time programmable half-period (in clock cycles) and mode: OFF, ON, continuous BLINK, or finite BURST of N pulses.
- Used for LED/status indication and test tones in the keyboard design.
- Includes a global phase-sync input and per-channel toggle strobes for downstream logic.

---
 rtl/multi_blinker.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/multi_blinker.sv
// multi_blinker: C_CH independent square-wave / burst generators sharing one
// configuration bus and one phase-sync input.
//
// Each channel has a mode (OFF, ON, BLINK, BURST) and a half-period in clock
// cycles. BLINK toggles out every `half` cycles forever. BURST emits
// cfg_burst high pulses, then falls back to OFF.
//
// Ports:
//   clk       in   main clock, rising edge
//   rst       in   synchronous active-high reset (all channels -> default BLINK)
//   cfg_we    in   configuration write strobe
//   cfg_ch    in   target channel of the write (out-of-range writes are ignored)
//   cfg_mode  in   0 OFF, 1 ON, 2 BLINK, 3 BURST
//   cfg_half  in   half-period in cycles (0 is treated as 1)
//   cfg_burst in   number of high pulses for BURST
//   sync      in   restarts the phase of every BLINK channel
//   out       out  channel outputs (registered)
//   tick      out  one-cycle pulse on the edge where out toggles
//   busy      out  high while a BURST is in progress
module multi_blinker #(
  parameter int C_CLK_FRQ = 100_000_000,
  parameter int C_CH      = 4,
  parameter int C_CNT_W   = 32,
  parameter int C_PERIOD  = 10,
  localparam int CH_W     = (C_CH > 1) ? $clog2(C_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [C_CNT_W-1:0] cfg_half,
  input  logic [7:0]         cfg_burst,
  input  logic               sync,
  output logic [C_CH-1:0]    out,
  output logic [C_CH-1:0]    tick,
  output logic [C_CH-1:0]    busy
);

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_BURST = 2'd3
  } mode_t;

  // Default half-period after reset; computed in 64 bits so large clock
  // frequencies do not overflow before the final narrowing.
  localparam longint unsigned HALF_DEF_L =
    longint'(C_CLK_FRQ) / 64'd1000 * longint'(C_PERIOD) / 64'd2;
  localparam logic [C_CNT_W-1:0] C_HALF_DEF = C_CNT_W'(HALF_DEF_L);
  localparam logic [C_CNT_W-1:0] ONE        = C_CNT_W'(1);

  mode_t              mode_q [C_CH];
  mode_t              mode_d [C_CH];
  logic [C_CNT_W-1:0] half_q [C_CH];
  logic [C_CNT_W-1:0] half_d [C_CH];
  logic [C_CNT_W-1:0] cnt_q  [C_CH];
  logic [C_CNT_W-1:0] cnt_d  [C_CH];
  logic [7:0]         rem_q  [C_CH];
  logic [7:0]         rem_d  [C_CH];
  logic [C_CH-1:0]    out_q, out_d;
  logic [C_CH-1:0]    tick_q, tick_d;
  logic [C_CH-1:0]    busy_q, busy_d;

  // State register
  always_ff @(posedge clk) begin
    for (int i = 0; i < C_CH; i++) begin
      if (rst) begin
        mode_q[i] <= M_BLINK;
        half_q[i] <= C_HALF_DEF;
        cnt_q[i]  <= '0;
        rem_q[i]  <= '0;
        out_q[i]  <= 1'b0;
        tick_q[i] <= 1'b0;
        busy_q[i] <= 1'b0;
      end else begin
        mode_q[i] <= mode_d[i];
        half_q[i] <= half_d[i];
        cnt_q[i]  <= cnt_d[i];
        rem_q[i]  <= rem_d[i];
        out_q[i]  <= out_d[i];
        tick_q[i] <= tick_d[i];
        busy_q[i] <= busy_d[i];
      end
    end
  end

  // Next-state logic. Per channel: config write beats sync beats the
  // terminal-count toggle, so a write landing on a terminal count suppresses
  // that toggle and its tick.
  always_comb begin
    for (int i = 0; i < C_CH; i++) begin
      mode_d[i] = mode_q[i];
      half_d[i] = half_q[i];
      cnt_d[i]  = cnt_q[i];
      rem_d[i]  = rem_q[i];
      out_d[i]  = out_q[i];
      tick_d[i] = 1'b0;
      busy_d[i] = busy_q[i];

      if (cfg_we && (int'(cfg_ch) == i)) begin
        // A zero half-period would never match half-1; clamp to 1.
        half_d[i] = (cfg_half == '0) ? ONE : cfg_half;
        cnt_d[i]  = '0;
        mode_d[i] = mode_t'(cfg_mode);
        out_d[i]  = (mode_t'(cfg_mode) == M_ON);
        rem_d[i]  = '0;
        busy_d[i] = 1'b0;
        if (mode_t'(cfg_mode) == M_BURST) begin
          rem_d[i]  = cfg_burst;
          busy_d[i] = (cfg_burst != 8'd0);
          // An empty burst is simply an idle channel.
          if (cfg_burst == 8'd0) begin
            mode_d[i] = M_OFF;
          end
        end
      end else if (sync && (mode_q[i] == M_BLINK)) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
      end else if ((mode_q[i] == M_BLINK) || (mode_q[i] == M_BURST)) begin
        if (cnt_q[i] == (half_q[i] - ONE)) begin
          cnt_d[i]  = '0;
          out_d[i]  = ~out_q[i];
          tick_d[i] = 1'b1;
          // Pulses are counted on their falling edge; the last fall ends
          // the burst on the same edge, leaving out low and tick asserted.
          if ((mode_q[i] == M_BURST) && out_q[i]) begin
            rem_d[i] = rem_q[i] - 8'd1;
            if (rem_q[i] == 8'd1) begin
              mode_d[i] = M_OFF;
              busy_d[i] = 1'b0;
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    out  = out_q;
    tick = tick_q;
    busy = busy_q;
  end

endmodule
